// File: rtl/multicycle_decoder_if.sv
// Instruction-field inputs and datapath control outputs of the
// multicycle ARM main decoder.
interface multicycle_decoder_if #(
    parameter int CNT_W = 32
);
    logic [1:0]       Op;
    logic [5:0]       Funct;
    logic [3:0]       Rd;
    logic             Stall;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic [1:0]       FlagW;
    logic             NextPC;
    logic             IRWrite;
    logic             AdrSrc;
    logic [1:0]       ResultSrc;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ImmSrc;
    logic [1:0]       RegSrc;
    logic [1:0]       ALUControl;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCount;

    modport slave (
        input  Op, Funct, Rd, Stall,
        output PCS, RegW, MemW, FlagW, NextPC, IRWrite,
        output AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
        output ImmSrc, RegSrc, ALUControl, State, InstrCount
    );

    modport master (
        output Op, Funct, Rd, Stall,
        input  PCS, RegW, MemW, FlagW, NextPC, IRWrite,
        input  AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
        input  ImmSrc, RegSrc, ALUControl, State, InstrCount
    );
endinterface

// File: rtl/multicycle_decoder.sv
// Main control FSM and instruction decoder for the multicycle ARM
// datapath, with a retired-instruction counter.
module multicycle_decoder #(
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic reset,
    multicycle_decoder_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t           state;
    state_t           next;
    logic [CNT_W-1:0] count;
    logic             retire;
    logic             hold;
    logic             alu_op;
    logic             branch;
    logic             regw_raw;
    logic             memw_raw;
    logic             irw_raw;
    logic             npc_raw;
    logic [1:0]       alu_ctl;

    always_comb begin
        next = FETCH;
        unique case (state)
            FETCH:  next = DECODE;
            DECODE: begin
                unique case (bus.Op)
                    2'b00:   next = bus.Funct[5] ? EXECI : EXECR;
                    2'b01:   next = MEMADR;
                    2'b10:   next = BRANCH;
                    default: next = FETCH;
                endcase
            end
            MEMADR: next = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:  next = MEMWB;
            EXECR:  next = ALUWB;
            EXECI:  next = ALUWB;
            default: next = FETCH;
        endcase
    end

    // Only completed instructions count; Op11 bails out of DECODE.
    assign retire = (state == MEMWB) || (state == MEMWR) ||
                    (state == ALUWB) || (state == BRANCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            count <= '0;
        end else if (!bus.Stall) begin
            state <= next;
            if (retire)
                count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        irw_raw       = 1'b0;
        npc_raw       = 1'b0;
        regw_raw      = 1'b0;
        memw_raw      = 1'b0;
        alu_op        = 1'b0;
        branch        = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        unique case (state)
            FETCH: begin
                irw_raw       = 1'b1;
                npc_raw       = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            MEMADR: bus.ALUSrcB = 2'b01;
            MEMRD:  bus.AdrSrc  = 1'b1;
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                regw_raw      = 1'b1;
            end
            MEMWR: begin
                bus.AdrSrc = 1'b1;
                memw_raw   = 1'b1;
            end
            EXECR: alu_op = 1'b1;
            EXECI: begin
                bus.ALUSrcB = 2'b01;
                alu_op      = 1'b1;
            end
            ALUWB: regw_raw = 1'b1;
            BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                branch        = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_ctl = 2'b00;
        if (alu_op) begin
            unique case (bus.Funct[4:1])
                4'b0100: alu_ctl = 2'b00;
                4'b0010: alu_ctl = 2'b01;
                4'b0000: alu_ctl = 2'b10;
                4'b1100: alu_ctl = 2'b11;
                default: alu_ctl = 2'b00;
            endcase
        end
    end

    // Write strobes are killed by reset or stall; mux selects are not.
    assign hold           = reset | bus.Stall;
    assign bus.IRWrite    = irw_raw & ~hold;
    assign bus.NextPC     = npc_raw & ~hold;
    assign bus.RegW       = regw_raw & ~hold;
    assign bus.MemW       = memw_raw & ~hold;
    assign bus.PCS        = (branch | (regw_raw & (bus.Rd == 4'hF))) & ~hold;
    assign bus.FlagW[1]   = alu_op & bus.Funct[0] & ~hold;
    assign bus.FlagW[0]   = alu_op & bus.Funct[0] & ~alu_ctl[1] & ~hold;
    assign bus.ALUControl = alu_ctl;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.State      = state;
    assign bus.InstrCount = count;
endmodule

// File: tb/tb_multicycle_decoder.sv
// Scoreboarded random and directed test of multicycle_decoder against an
// instruction-level reference model.
module tb_multicycle_decoder;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multicycle_decoder_if #(.CNT_W(CNT_W)) bus ();

    multicycle_decoder #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]       state;
        logic             pcs;
        logic             regw;
        logic             memw;
        logic [1:0]       flagw;
        logic             npc;
        logic             irw;
        logic             adr;
        logic [1:0]       res;
        logic             srca;
        logic [1:0]       srcb;
        logic [1:0]       imm;
        logic [1:0]       regsrc;
        logic [1:0]       alu;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    obs_t expq[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cnt_m       = 0;

    function automatic obs_t model(int st, logic [1:0] op, logic [5:0] f,
                                   logic [3:0] rd, bit gated, int cnt);
        obs_t o;
        bit   aluop;
        bit   br;
        int   cmd;
        o      = '0;
        aluop  = 0;
        br     = 0;
        o.state  = 4'(st);
        o.imm    = op;
        o.regsrc = {op == 2'd1, op == 2'd2};
        o.cnt    = CNT_W'(cnt);
        case (st)
            0: begin o.irw = 1; o.npc = 1; o.srca = 1; o.srcb = 2; o.res = 2; end
            1: begin o.srca = 1; o.srcb = 2; o.res = 2; end
            2: o.srcb = 1;
            3: o.adr = 1;
            4: begin o.res = 1; o.regw = 1; end
            5: begin o.adr = 1; o.memw = 1; end
            6: aluop = 1;
            7: begin o.srcb = 1; aluop = 1; end
            8: o.regw = 1;
            9: begin o.srcb = 1; o.res = 2; br = 1; end
            default: ;
        endcase
        if (aluop) begin
            cmd   = int'(f[4:1]);
            o.alu = (cmd == 4)  ? 2'd0 :
                    (cmd == 2)  ? 2'd1 :
                    (cmd == 0)  ? 2'd2 :
                    (cmd == 12) ? 2'd3 : 2'd0;
            o.flagw[1] = f[0];
            o.flagw[0] = f[0] && (o.alu < 2);
        end
        o.pcs = br || (o.regw && rd == 4'd15);
        if (gated) begin
            o.pcs = 0; o.regw = 0; o.memw = 0;
            o.flagw = 0; o.npc = 0; o.irw = 0;
        end
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.state  = bus.State;
        o.pcs    = bus.PCS;
        o.regw   = bus.RegW;
        o.memw   = bus.MemW;
        o.flagw  = bus.FlagW;
        o.npc    = bus.NextPC;
        o.irw    = bus.IRWrite;
        o.adr    = bus.AdrSrc;
        o.res    = bus.ResultSrc;
        o.srca   = bus.ALUSrcA;
        o.srcb   = bus.ALUSrcB;
        o.imm    = bus.ImmSrc;
        o.regsrc = bus.RegSrc;
        o.alu    = bus.ALUControl;
        o.cnt    = bus.InstrCount;
        return o;
    endfunction

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = observe();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL cycle_outputs t=%0t: got state=%0d bits=%h cnt=%0d, expected state=%0d bits=%h cnt=%0d",
                         $time, a.state, a, a.cnt, e.state, e, e.cnt);
            end
        end
    end

    task automatic run(input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] rd, input int rst_at,
                       input int stall_at, input bit rnd);
        int path[$];
        int i;
        int stalls;
        bit st;
        bit rs;
        path = '{0, 1};
        case (op)
            2'd0: begin path.push_back(f[5] ? 7 : 6); path.push_back(8); end
            2'd1: begin
                path.push_back(2);
                if (f[0]) begin path.push_back(3); path.push_back(4); end
                else path.push_back(5);
            end
            2'd2: path.push_back(9);
            default: ;
        endcase
        bus.Op    = op;
        bus.Funct = f;
        bus.Rd    = rd;
        i         = 0;
        stalls    = 0;
        while (i < path.size()) begin
            st = 0;
            if (i == stall_at && stalls < 3) st = 1;
            else if (rnd && $urandom_range(4) == 0) st = 1;
            rs        = (i == rst_at) && !st;
            bus.Stall = st;
            reset     = rs;
            expq.push_back(model(path[i], op, f, rd, st || rs, cnt_m));
            @(posedge clk);
            #1;
            if (st) begin
                if (i == stall_at) stalls++;
            end else if (rs) begin
                reset = 0;
                cnt_m = 0;
                return;
            end else begin
                i++;
            end
        end
        if (op != 2'd3) cnt_m = (cnt_m + 1) % (1 << CNT_W);
    endtask

    initial begin
        reset     = 1;
        bus.Op    = 0;
        bus.Funct = 0;
        bus.Rd    = 0;
        bus.Stall = 0;
        @(posedge clk);
        #1;
        expq.push_back(model(0, 2'd0, 6'd0, 4'd0, 1, 0));
        @(posedge clk);
        #1;
        reset = 0;

        run(2'd1, 6'b011001, 4'd2,  -1, -1, 0);
        run(2'd1, 6'b011000, 4'd3,  -1,  3, 0);
        run(2'd0, 6'b001001, 4'd4,  -1, -1, 0);
        run(2'd0, 6'b100100, 4'd5,  -1, -1, 0);
        run(2'd0, 6'b000001, 4'd6,  -1, -1, 0);
        run(2'd0, 6'b011000, 4'd15, -1, -1, 0);
        run(2'd2, 6'b000000, 4'd0,  -1, -1, 0);
        run(2'd3, 6'b000000, 4'd0,  -1, -1, 0);
        run(2'd1, 6'b011001, 4'd1,   3, -1, 0);

        for (int n = 0; n < 300; n++) begin
            int ra;
            ra = ($urandom_range(19) == 0) ? int'($urandom_range(3)) : -1;
            run(2'($urandom_range(3)), 6'($urandom_range(63)),
                4'($urandom_range(15)), ra, -1, 1);
        end

        @(posedge clk);
        @(posedge clk);
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
